// File: rtl/stack_ctrl_pkg.sv
// Shared types and constants for the stack access arbiter and its arbiter sub-block.
package stack_ctrl_pkg;

  localparam int STACK_DEPTH = 5;
  localparam int STACK_WIDTH = 4;

  typedef enum logic [1:0] {
    NOP  = 2'b00,
    PUSH = 2'b01,
    POP  = 2'b10,
    GET  = 2'b11
  } cmd_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_READ  = 3'd2,
    S_RESP  = 3'd3,
    S_CLEAR = 3'd4
  } state_t;

  // An op is rejected when it would overflow, underflow, read past the live
  // entries, or carries the invalid 00 command.
  function automatic logic op_illegal(input cmd_t cmd, input logic [2:0] idx,
                                      input logic [2:0] occ, input logic [2:0] depth);
    logic bad;
    case (cmd)
      PUSH:    bad = (occ == depth);
      POP:     bad = (occ == 3'd0);
      GET:     bad = (idx >= occ);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from the requester after the
// last accepted grantee; the pointer only moves when the grant is accepted.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic [N-1:0] req_i,
  input  logic         advance_i,
  output logic [N-1:0] grant_o
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] nxt_s;
  logic          found_s;
  logic          hit_s;
  int            idx_s;

  // Rotating priority search starting at ptr_q; first requester found wins.
  always_comb begin
    grant_o = '0;
    nxt_s   = ptr_q;
    found_s = 1'b0;
    hit_s   = 1'b0;
    idx_s   = 0;
    for (int k = 0; k < N; k++) begin
      idx_s          = (int'(ptr_q) + k) % N;
      hit_s          = !found_s && req_i[idx_s];
      grant_o[idx_s] = grant_o[idx_s] | hit_s;
      nxt_s          = hit_s ? PW'((idx_s + 1) % N) : nxt_s;
      found_s        = found_s | hit_s;
    end
  end

  // Pointer register: moves past the winner only when the grant is taken.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ptr_q <= '0;
    end else if (advance_i) begin
      ptr_q <= nxt_s;
    end
  end

endmodule

// File: rtl/stack_access_arbiter.sv
// Shares one stack between N_REQ requesters with a single op in flight:
// arbitrates, sequences the stack command bus, captures read data on the
// falling edge of the READ cycle and returns one response per op.
module stack_access_arbiter
  import stack_ctrl_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int DEPTH = STACK_DEPTH,
  parameter int WIDTH = STACK_WIDTH
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic                   SOFT_CLEAR,
  input  logic [N_REQ-1:0]       REQ_VALID,
  input  logic [2*N_REQ-1:0]     REQ_CMD,
  input  logic [3*N_REQ-1:0]     REQ_INDEX,
  input  logic [WIDTH*N_REQ-1:0] REQ_DATA,
  output logic [N_REQ-1:0]       REQ_READY,
  output logic [N_REQ-1:0]       RSP_VALID,
  output logic [WIDTH-1:0]       RSP_DATA,
  output logic                   RSP_ERR,
  output logic [2:0]             OCCUPANCY,
  output logic                   STK_RESET,
  output logic [1:0]             STK_COMMAND,
  output logic [2:0]             STK_INDEX,
  output logic [WIDTH-1:0]       STK_WDATA,
  output logic                   STK_WDATA_OE,
  input  logic [WIDTH-1:0]       STK_RDATA
);

  state_t             state_q, state_d;
  cmd_t               cmd_q, cmd_d;
  logic [2:0]         idx_q, idx_d;
  logic [2:0]         occ_q, occ_d;
  logic [WIDTH-1:0]   wdata_q, wdata_d;
  logic [WIDTH-1:0]   rdata_q;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic               err_q, err_d;
  logic               en_q;
  logic               stk_rst_q;

  logic [N_REQ-1:0]   grant_s;
  logic               accept_s;
  int                 win_s;
  logic [1:0]         sel_cmd_s;
  logic [2:0]         sel_idx_s;
  logic [WIDTH-1:0]   sel_data_s;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .clk_i     (CLK),
    .rst_n_i   (RESET_N),
    .req_i     (REQ_VALID),
    .advance_i (accept_s),
    .grant_o   (grant_s)
  );

  // Grants are only handed out from IDLE, never while a clear is requested,
  // and not in the first cycle out of reset.
  assign accept_s  = (state_q == S_IDLE) && !SOFT_CLEAR && en_q && (|grant_s);
  assign REQ_READY = accept_s ? grant_s : '0;

  // Winner index and its request fields.
  always_comb begin
    win_s = 0;
    for (int i = 0; i < N_REQ; i++) begin
      win_s = grant_s[i] ? i : win_s;
    end
    sel_cmd_s  = REQ_CMD[win_s*2 +: 2];
    sel_idx_s  = REQ_INDEX[win_s*3 +: 3];
    sel_data_s = REQ_DATA[win_s*WIDTH +: WIDTH];
  end

  // Next-state, operation latch and occupancy bookkeeping.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    gnt_d   = gnt_q;
    err_d   = err_q;
    occ_d   = occ_q;
    case (state_q)
      S_IDLE: begin
        if (SOFT_CLEAR) begin
          state_d = S_CLEAR;
        end else if (accept_s) begin
          cmd_d   = cmd_t'(sel_cmd_s);
          idx_d   = sel_idx_s;
          wdata_d = sel_data_s;
          gnt_d   = grant_s;
          err_d   = op_illegal(cmd_t'(sel_cmd_s), sel_idx_s, occ_q, 3'(DEPTH));
          state_d = err_d ? S_RESP : S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        case (cmd_q)
          PUSH: begin
            occ_d   = occ_q + 3'd1;
            state_d = S_RESP;
          end
          POP: begin
            occ_d   = occ_q - 3'd1;
            state_d = S_READ;
          end
          GET:     state_d = S_READ;
          default: state_d = S_RESP;
        endcase
      end
      S_READ:  state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      S_CLEAR: begin
        occ_d   = 3'd0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state, latched op and the stack reset strobe.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= S_IDLE;
      cmd_q     <= NOP;
      idx_q     <= 3'd0;
      occ_q     <= 3'd0;
      wdata_q   <= '0;
      gnt_q     <= '0;
      err_q     <= 1'b0;
      en_q      <= 1'b0;
      stk_rst_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      idx_q     <= idx_d;
      occ_q     <= occ_d;
      wdata_q   <= wdata_d;
      gnt_q     <= gnt_d;
      err_q     <= err_d;
      en_q      <= 1'b1;
      stk_rst_q <= (state_d == S_CLEAR);
    end
  end

  // Read capture mid-cycle: the stack drives IO_DATA only while CLK is high.
  always_ff @(negedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rdata_q <= '0;
    end else if (state_q == S_READ) begin
      rdata_q <= STK_RDATA;
    end
  end

  assign RSP_VALID    = (state_q == S_RESP) ? gnt_q : '0;
  assign RSP_ERR      = (state_q == S_RESP) && err_q;
  assign RSP_DATA     = ((state_q == S_RESP) && !err_q && ((cmd_q == POP) || (cmd_q == GET)))
                        ? rdata_q : '0;
  assign OCCUPANCY    = occ_q;
  assign STK_RESET    = stk_rst_q;
  // Only ISSUE ever puts a command on the stack bus; the read cycle and the
  // response cycle both hold 00, so the stack never drives while OE is high.
  assign STK_COMMAND  = (state_q == S_ISSUE) ? cmd_q : NOP;
  assign STK_INDEX    = (state_q == S_ISSUE) ? idx_q : 3'd0;
  assign STK_WDATA_OE = (state_q == S_ISSUE) && (cmd_q == PUSH);
  assign STK_WDATA    = STK_WDATA_OE ? wdata_q : '0;

endmodule

// File: tb/tb_stack_access_arbiter.sv
// Directed bench with a behavioural stack model and a response scoreboard.
module tb_stack_access_arbiter;
  import stack_ctrl_pkg::*;

  localparam int N = 2;
  localparam int W = 4;

  logic           CLK = 1'b0;
  logic           RESET_N = 1'b0;
  logic           SOFT_CLEAR = 1'b0;
  logic [N-1:0]   REQ_VALID;
  logic [2*N-1:0] REQ_CMD;
  logic [3*N-1:0] REQ_INDEX;
  logic [W*N-1:0] REQ_DATA;
  logic [N-1:0]   REQ_READY, RSP_VALID;
  logic [W-1:0]   RSP_DATA, STK_WDATA;
  logic [W-1:0]   STK_RDATA = 4'hE;
  logic           RSP_ERR, STK_RESET, STK_WDATA_OE;
  logic [2:0]     OCCUPANCY, STK_INDEX;
  logic [1:0]     STK_COMMAND;

  logic           v_valid [N];
  logic [1:0]     v_cmd   [N];
  logic [2:0]     v_idx   [N];
  logic [W-1:0]   v_data  [N];

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign REQ_VALID[g]           = v_valid[g];
    assign REQ_CMD[g*2 +: 2]      = v_cmd[g];
    assign REQ_INDEX[g*3 +: 3]    = v_idx[g];
    assign REQ_DATA[g*W +: W]     = v_data[g];
  end

  stack_access_arbiter #(.N_REQ(N), .DEPTH(5), .WIDTH(W)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .SOFT_CLEAR(SOFT_CLEAR),
    .REQ_VALID(REQ_VALID), .REQ_CMD(REQ_CMD), .REQ_INDEX(REQ_INDEX), .REQ_DATA(REQ_DATA),
    .REQ_READY(REQ_READY), .RSP_VALID(RSP_VALID), .RSP_DATA(RSP_DATA), .RSP_ERR(RSP_ERR),
    .OCCUPANCY(OCCUPANCY), .STK_RESET(STK_RESET), .STK_COMMAND(STK_COMMAND),
    .STK_INDEX(STK_INDEX), .STK_WDATA(STK_WDATA), .STK_WDATA_OE(STK_WDATA_OE),
    .STK_RDATA(STK_RDATA)
  );

  always #5 CLK = ~CLK;

  typedef struct { int req; int data; int err; int occ; int lat; } exp_t;
  exp_t sbq[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int ready_cyc = 0;
  int cmd_cnt = 0;
  int rst_cnt = 0;
  logic [1:0] prev_cmd = 2'b00;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Stack model: commands sampled mid-cycle, applied after the edge,
  // read data driven only during the high phase of the following cycle.
  logic [W-1:0] smem [5];
  int           sp = 0;
  logic [1:0]   cap_cmd = 2'b00;
  logic [2:0]   cap_idx = 3'd0;
  logic [W-1:0] cap_wd = 4'h0;
  logic         cap_oe = 1'b0;
  logic         cap_rst = 1'b0;

  always @(negedge CLK) begin
    cap_cmd = STK_COMMAND;
    cap_idx = STK_INDEX;
    cap_wd  = STK_WDATA;
    cap_oe  = STK_WDATA_OE;
    cap_rst = STK_RESET;
  end

  always @(posedge CLK) begin
    logic         drive;
    logic [W-1:0] rd;
    drive = 1'b0;
    rd    = 4'h0;
    #1;
    if (cap_rst) begin
      sp = 0;
    end else begin
      case (cap_cmd)
        2'b01: begin
          check("push_oe", int'(cap_oe), 1);
          if (sp < 5) begin smem[sp] = cap_wd; sp++; end
          else check("stack_overflow", sp, 4);
        end
        2'b10: begin
          if (sp > 0) begin sp--; rd = smem[sp]; drive = 1'b1; end
          else check("stack_underflow", sp, 1);
        end
        2'b11: begin
          if (int'(cap_idx) < sp) begin rd = smem[sp-1-int'(cap_idx)]; drive = 1'b1; end
          else check("stack_get_range", int'(cap_idx), sp - 1);
        end
        default: ;
      endcase
    end
    if (drive) begin
      STK_RDATA = rd;
      @(negedge CLK);
      #2 STK_RDATA = 4'hE;
    end
  end

  always @(posedge CLK) cyc <= cyc + 1;

  // Monitor: protocol checks every cycle, scoreboard pop on each response.
  always @(negedge CLK) begin
    exp_t e;
    int   ri;
    check("ready_onehot", int'($onehot0(REQ_READY)), 1);
    check("rsp_onehot", int'($onehot0(RSP_VALID)), 1);
    if (prev_cmd == 2'b10 || prev_cmd == 2'b11) check("oe_after_read", int'(STK_WDATA_OE), 0);
    prev_cmd = STK_COMMAND;
    if (STK_COMMAND != 2'b00) cmd_cnt++;
    if (STK_RESET) rst_cnt++;
    if (|REQ_READY) ready_cyc = cyc;
    if (|RSP_VALID) begin
      ri = RSP_VALID[1] ? 1 : 0;
      if (sbq.size() == 0) begin
        check("unexpected_rsp_req", ri, -1);
      end else begin
        e = sbq.pop_front();
        check("rsp_req", ri, e.req);
        check("rsp_data", int'(RSP_DATA), e.data);
        check("rsp_err", int'(RSP_ERR), e.err);
        check("rsp_occ", int'(OCCUPANCY), e.occ);
        check("rsp_latency", cyc - ready_cyc, e.lat);
      end
    end
  end

  task automatic expect_rsp(input int r, input int d, input int e, input int o, input int l);
    exp_t x;
    x = '{req: r, data: d, err: e, occ: o, lat: l};
    sbq.push_back(x);
  endtask

  // Present one request at a negedge and drop it after it has been accepted.
  task automatic run_op(input int r, input logic [1:0] c, input logic [2:0] ix, input logic [W-1:0] d);
    bit got;
    got = 1'b0;
    v_cmd[r] = c; v_idx[r] = ix; v_data[r] = d; v_valid[r] = 1'b1;
    for (int k = 0; k < 60 && !got; k++) begin
      #1;
      if (REQ_READY[r]) got = 1'b1;
      @(negedge CLK);
    end
    v_valid[r] = 1'b0;
    check("grant_seen", int'(got), 1);
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 100 && sbq.size() != 0; k++) @(negedge CLK);
    check("drain", sbq.size(), 0);
    @(negedge CLK);
  endtask

  initial begin
    int c0;
    bit got;
    for (int i = 0; i < N; i++) begin
      v_valid[i] = 1'b0; v_cmd[i] = 2'b00; v_idx[i] = 3'd0; v_data[i] = 4'h0;
    end
    // Reset state, with a request already pending.
    v_valid[0] = 1'b1; v_cmd[0] = 2'b01;
    repeat (2) @(negedge CLK);
    #1;
    check("rst_stk_reset", int'(STK_RESET), 1);
    check("rst_occ", int'(OCCUPANCY), 0);
    check("rst_ready", int'(REQ_READY), 0);
    check("rst_rsp_valid", int'(RSP_VALID), 0);
    check("rst_cmd", int'(STK_COMMAND), 0);
    check("rst_oe", int'(STK_WDATA_OE), 0);
    check("rst_rsp_data", int'(RSP_DATA), 0);
    v_valid[0] = 1'b0;
    @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);

    // 1: push 3, 5 then pop 5.
    expect_rsp(0, 0, 0, 1, 2); run_op(0, 2'b01, 3'd0, 4'h3);
    expect_rsp(0, 0, 0, 2, 2); run_op(0, 2'b01, 3'd0, 4'h5);
    expect_rsp(0, 5, 0, 1, 3); run_op(0, 2'b10, 3'd0, 4'h0);
    wait_drain();

    // 2: get top via req1, then both requesters push continuously.
    expect_rsp(1, 3, 0, 1, 3); run_op(1, 2'b11, 3'd0, 4'h0);
    wait_drain();
    expect_rsp(0, 0, 0, 2, 2); expect_rsp(1, 0, 0, 3, 2);
    expect_rsp(0, 0, 0, 4, 2); expect_rsp(1, 0, 0, 5, 2);
    fork
      begin run_op(0, 2'b01, 3'd0, 4'h6); run_op(0, 2'b01, 3'd0, 4'h8); end
      begin run_op(1, 2'b01, 3'd0, 4'h7); run_op(1, 2'b01, 3'd0, 4'h9); end
    join
    wait_drain();
    check("full_occ", int'(OCCUPANCY), 5);
    check("full_model_sp", sp, 5);

    // 3: sixth push rejected, no stack command.
    c0 = cmd_cnt;
    expect_rsp(0, 0, 1, 5, 1); run_op(0, 2'b01, 3'd0, 4'hF);
    wait_drain();
    check("full_no_cmd", cmd_cnt - c0, 0);

    // 4: drain in LIFO order, then pop on empty.
    expect_rsp(1, 9, 0, 4, 3); run_op(1, 2'b10, 3'd0, 4'h0);
    expect_rsp(1, 8, 0, 3, 3); run_op(1, 2'b10, 3'd0, 4'h0);
    expect_rsp(1, 7, 0, 2, 3); run_op(1, 2'b10, 3'd0, 4'h0);
    expect_rsp(1, 6, 0, 1, 3); run_op(1, 2'b10, 3'd0, 4'h0);
    expect_rsp(1, 3, 0, 0, 3); run_op(1, 2'b10, 3'd0, 4'h0);
    wait_drain();
    c0 = cmd_cnt;
    expect_rsp(1, 0, 1, 0, 1); run_op(1, 2'b10, 3'd0, 4'h0);
    expect_rsp(0, 0, 1, 0, 1); run_op(0, 2'b00, 3'd0, 4'h0);
    wait_drain();
    check("empty_no_cmd", cmd_cnt - c0, 0);

    // 5: get at depth.
    expect_rsp(0, 0, 0, 1, 2); run_op(0, 2'b01, 3'd0, 4'h1);
    expect_rsp(0, 0, 0, 2, 2); run_op(0, 2'b01, 3'd0, 4'h2);
    expect_rsp(0, 0, 0, 3, 2); run_op(0, 2'b01, 3'd0, 4'h3);
    expect_rsp(0, 1, 0, 3, 3); run_op(0, 2'b11, 3'd2, 4'h0);
    expect_rsp(0, 3, 0, 3, 3); run_op(0, 2'b11, 3'd0, 4'h0);
    expect_rsp(0, 0, 1, 3, 1); run_op(0, 2'b11, 3'd3, 4'h0);
    wait_drain();

    // 6a: soft clear wins over a pending request, which is served afterwards.
    c0 = rst_cnt;
    expect_rsp(1, 0, 0, 1, 2);
    fork
      begin
        SOFT_CLEAR = 1'b1;
        @(negedge CLK);
        #1;
        check("clear_stk_reset", int'(STK_RESET), 1);
        SOFT_CLEAR = 1'b0;
        @(negedge CLK);
        #1;
        check("clear_occ", int'(OCCUPANCY), 0);
      end
      begin run_op(1, 2'b01, 3'd0, 4'hA); end
    join
    wait_drain();
    check("clear_one_cycle", rst_cnt - c0, 1);
    check("clear_model_sp", sp, 1);

    // 6b: async reset in the READ cycle drops the op without a response.
    fork
      begin run_op(0, 2'b10, 3'd0, 4'h0); end
      begin
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
          @(negedge CLK);
          if (STK_COMMAND == 2'b10) got = 1'b1;
        end
        check("pop_issued", int'(got), 1);
        @(posedge CLK);
        #2 RESET_N = 1'b0;
        #1;
        check("rstrd_rsp_valid", int'(RSP_VALID), 0);
        check("rstrd_occ", int'(OCCUPANCY), 0);
        check("rstrd_stk_reset", int'(STK_RESET), 1);
        check("rstrd_cmd", int'(STK_COMMAND), 0);
      end
    join
    repeat (3) @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
    expect_rsp(0, 0, 0, 1, 2); run_op(0, 2'b01, 3'd0, 4'h5);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
